r16_in_mux_pipe: RTL and testbench
==================================

// Module: r16_in_mux_pipe
// PURPOSE
//  Parametrised, pipelined successor of the radix-16 butterfly input selector. It sits between
//  the data/twiddle memory read ports and the R16 butterfly core. Per accepted beat it routes
//  LANES data words and LANES twiddles according to a per-beat mode (normal / last-stage radix-2 /
//  twiddle bypass). A one-entry skid buffer provides full-throughput valid/ready buffering, and a
//  beat counter flags the last beat of each stage.
// PARAMETERS
//  D_WIDTH   64   data/twiddle word width (matches `D_width)
//  LANES     16   butterfly lanes; power of two, >=2
//  BEATS     64   beats per stage; beat counter wraps at BEATS-1
//  TW_ONE    1    twiddle value driven in BYPASS mode (Montgomery/plain one)
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               asynchronous active-low reset
//  in_valid   in   1               input beat valid
//  in_ready   out  1               block can accept a beat
//  in_mode    in   2               0=NORMAL 1=LAST_R2 2=BYPASS 3=reserved (treated as NORMAL)
//  in_x       in   LANES*D_WIDTH   packed data, lane i = [i*D_WIDTH +: D_WIDTH]
//  in_tw      in   LANES*D_WIDTH   packed twiddles, same packing
//  out_valid  out  1               output beat valid
//  out_ready  in   1               downstream accepts beat
//  out_x      out  LANES*D_WIDTH   routed data to butterfly
//  out_tw     out  LANES*D_WIDTH   routed twiddles to butterfly
//  out_last   out  1               beat is the last of the stage (count==BEATS-1)
//  out_mode   out  2               mode of the presented beat
// BEHAVIOUR
//  Reset (async on rst_n low): out_valid=0, out_x=0, out_tw=0, out_last=0, out_mode=0,
//   skid buffer empty, beat counter=0; in_ready=1 from the first edge after rst_n rises.
//  Routing (combinational, applied before registration):
//   NORMAL : lane i x = in_x[i], tw = in_tw[i] for all i.
//   LAST_R2: lane 0 x = in_x[0]; lane LANES/2 x = in_x[1]; lane 1 tw = in_tw[0];
//            all other x and tw lanes = 0.
//   BYPASS : x lanes as NORMAL; every tw lane = TW_ONE.
//  Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
//   Latency is exactly 1 cycle (in transfer at edge N -> out_valid at N+1 when the output reg is
//   free). Throughput is 1 beat/cycle under continuous out_ready.
//   Skid: if output reg holds an unaccepted beat and a new beat arrives, the new beat goes to the
//   skid reg and in_ready drops to 0 next cycle. in_ready = !skid_full.
//   When the output transfers: output reg <- skid (if full, skid then emptied) else <- new input
//   beat (if one transfers), else out_valid=0. Simultaneous in/out transfer with skid empty:
//   output reg loads new beat, out_valid stays 1.
//   out_* are stable while out_valid && !out_ready. Beat order is strictly preserved.
//  Beat counter: increments on each input transfer; wraps BEATS-1 -> 0. out_last and out_mode
//   travel with the beat (captured at input transfer, buffered through skid).
//  Mode is sampled per beat; mode changes between beats need no flush.
//  Reset mid-operation discards the buffered beats and the count.
//  No arithmetic is performed; widths pass through unchanged.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> out_valid=0, in_ready=1 after release, first beat out_last=0.
//  2. NORMAL, lanes x=i+1, tw=100+i, out_ready=1 -> identical lanes 1 cycle later.
//  3. LAST_R2, x0=0xA, x1=0xB, tw0=0x5 -> lane0 x=0xA, lane8 x=0xB, lane1 tw=0x5, all others 0.
//  4. Backpressure: out_ready=0 for 3 cycles, in_valid=1 -> 2 beats held, in_ready=0; release ->
//     beats emerge in order with no loss or duplicate.
//  5. 2*BEATS continuous NORMAL beats -> out_last=1 exactly on beats 63 and 127 (BEATS=64).
//  6. BYPASS with random tw -> every out_tw lane = TW_ONE, x unchanged; LANES=4 build passes.

Source files
------------

// File: rtl/r16_in_mux_pipe.sv
// r16_in_mux_pipe
// Input selector in front of the radix-16 butterfly core. Each accepted beat
// carries LANES data words and LANES twiddles that are routed by a per-beat
// mode, then registered once. A one-entry skid register keeps full throughput
// under valid/ready backpressure, and a beat counter tags the last beat of
// every stage. No arithmetic is done on the words; they pass through unchanged.
module r16_in_mux_pipe #(
    parameter int                 D_WIDTH = 64,
    parameter int                 LANES   = 16,
    parameter int                 BEATS   = 64,
    parameter logic [D_WIDTH-1:0] TW_ONE  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic [LANES*D_WIDTH-1:0] in_x,
    input  logic [LANES*D_WIDTH-1:0] in_tw,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*D_WIDTH-1:0] out_x,
    output logic [LANES*D_WIDTH-1:0] out_tw,
    output logic                     out_last,
    output logic [1:0]               out_mode
);

    localparam int VEC_W = LANES * D_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS - 1);

    // Mode code 3 is reserved and routes exactly like NORMAL.
    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_LAST_R2 = 2'd1,
        MODE_BYPASS  = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // LAST_R2 keeps only the two radix-2 inputs: x0 stays on lane 0 and x1
    // moves to lane LANES/2, where the core expects the second operand.
    function automatic logic [VEC_W-1:0] route_x(input mode_e mode,
                                                 input logic [VEC_W-1:0] x);
        logic [VEC_W-1:0] r;
        r = x;
        if (mode == MODE_LAST_R2) begin
            r = '0;
            r[0 +: D_WIDTH]                   = x[0 +: D_WIDTH];
            r[(LANES/2)*D_WIDTH +: D_WIDTH]   = x[D_WIDTH +: D_WIDTH];
        end
        return r;
    endfunction

    // LAST_R2 places the single twiddle on lane 1; BYPASS forces the
    // multiplicative identity on every lane so the core multiply is a no-op.
    function automatic logic [VEC_W-1:0] route_tw(input mode_e mode,
                                                  input logic [VEC_W-1:0] tw);
        logic [VEC_W-1:0] r;
        r = tw;
        case (mode)
            MODE_LAST_R2: begin
                r = '0;
                r[D_WIDTH +: D_WIDTH] = tw[0 +: D_WIDTH];
            end
            MODE_BYPASS: begin
                for (int i = 0; i < LANES; i++) begin
                    r[i*D_WIDTH +: D_WIDTH] = TW_ONE;
                end
            end
            default: r = tw;
        endcase
        return r;
    endfunction

    // ---- stage p0: combinational routing of the incoming beat ----
    logic [VEC_W-1:0] x_p0;
    logic [VEC_W-1:0] tw_p0;
    logic             last_p0;
    logic [1:0]       mode_p0;
    logic [CNT_W-1:0] beat_cnt;
    logic             in_fire;
    logic             out_free;

    assign x_p0    = route_x(mode_e'(in_mode), in_x);
    assign tw_p0   = route_tw(mode_e'(in_mode), in_tw);
    assign last_p0 = (beat_cnt == CNT_MAX);
    assign mode_p0 = in_mode;

    // ---- skid entry: holds one beat while the output register is stalled ----
    logic [VEC_W-1:0] x_sk;
    logic [VEC_W-1:0] tw_sk;
    logic             last_sk;
    logic [1:0]       mode_sk;
    logic             skid_full;

    // ---- stage p1: output register presented to the butterfly ----
    logic [VEC_W-1:0] x_p1;
    logic [VEC_W-1:0] tw_p1;
    logic             last_p1;
    logic [1:0]       mode_p1;
    logic             vld_p1;

    assign in_ready = !skid_full;
    assign in_fire  = in_valid && in_ready;
    // The output register can take a new beat when empty or being consumed.
    assign out_free = !vld_p1 || out_ready;

    assign out_valid = vld_p1;
    assign out_x     = x_p1;
    assign out_tw    = tw_p1;
    assign out_last  = last_p1;
    assign out_mode  = mode_p1;

    // Stage beat counter: advances per accepted beat and wraps at BEATS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (in_fire) begin
            beat_cnt <= last_p0 ? '0 : beat_cnt + 1'b1;
        end
    end

    // Skid occupancy: fills when a beat arrives against a stalled output,
    // drains whenever the output register is free to take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_full <= 1'b0;
        end else if (out_free) begin
            skid_full <= 1'b0;
        end else if (in_fire) begin
            skid_full <= 1'b1;
        end
    end

    // Skid payload: only meaningful while skid_full, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!out_free && in_fire) begin
            x_sk    <= x_p0;
            tw_sk   <= tw_p0;
            last_sk <= last_p0;
            mode_sk <= mode_p0;
        end
    end

    // Output register: the skid beat has priority so order is preserved;
    // otherwise take the new beat, otherwise go idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            x_p1    <= '0;
            tw_p1   <= '0;
            last_p1 <= 1'b0;
            mode_p1 <= 2'd0;
        end else if (out_free) begin
            if (skid_full) begin
                vld_p1  <= 1'b1;
                x_p1    <= x_sk;
                tw_p1   <= tw_sk;
                last_p1 <= last_sk;
                mode_p1 <= mode_sk;
            end else if (in_fire) begin
                vld_p1  <= 1'b1;
                x_p1    <= x_p0;
                tw_p1   <= tw_p0;
                last_p1 <= last_p0;
                mode_p1 <= mode_p0;
            end else begin
                vld_p1  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_r16_in_mux_pipe.sv
// Bench for r16_in_mux_pipe: directed beats with hand-computed lane values,
// a beat scoreboard fed from accepted inputs, and a small LANES=4 build.
module tb_r16_in_mux_pipe;

    localparam int DW = 64;
    localparam int L  = 16;
    localparam int B  = 64;
    localparam int W  = DW * L;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [W-1:0] in_x;
    logic [W-1:0] in_tw;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_x;
    logic [W-1:0] out_tw;
    logic         out_last;
    logic [1:0]   out_mode;

    // Small build: 4 lanes of 16 bits, 4 beats per stage.
    logic         in_valid4;
    logic         in_ready4;
    logic [1:0]   in_mode4;
    logic [63:0]  in_x4;
    logic [63:0]  in_tw4;
    logic         out_valid4;
    logic         out_ready4;
    logic [63:0]  out_x4;
    logic [63:0]  out_tw4;
    logic         out_last4;
    logic [1:0]   out_mode4;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] tw;
        logic         last;
        logic [1:0]   mode;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        b;
    int           tb_cnt;
    int           out_idx;
    int           lasts_seen;
    bit           hold;
    logic [W-1:0] hx;
    logic [W-1:0] htw;
    logic [2:0]   hctl;
    bit           rand_ready = 0;

    logic [W-1:0] vx;
    logic [W-1:0] vtw;
    logic [63:0]  a_lane0;
    bit           acc;
    logic [15:0]  e16;

    r16_in_mux_pipe #(.D_WIDTH(DW), .LANES(L), .BEATS(B), .TW_ONE(64'd1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_tw(in_tw),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_tw(out_tw), .out_last(out_last), .out_mode(out_mode)
    );

    r16_in_mux_pipe #(.D_WIDTH(16), .LANES(4), .BEATS(4), .TW_ONE(16'h0001)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_mode(in_mode4),
        .in_x(in_x4), .in_tw(in_tw4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_x(out_x4), .out_tw(out_tw4), .out_last(out_last4), .out_mode(out_mode4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference routing, written from the mode table.
    function automatic logic [W-1:0] m_x(input logic [1:0] md, input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        if (md == 2'd1) begin
            r = '0;
            r[0 +: DW]          = x[0 +: DW];
            r[(L/2)*DW +: DW]   = x[DW +: DW];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] m_tw(input logic [1:0] md, input logic [W-1:0] tw);
        logic [W-1:0] r;
        r = tw;
        if (md == 2'd1) begin
            r = '0;
            r[DW +: DW] = tw[0 +: DW];
        end else if (md == 2'd2) begin
            for (int i = 0; i < L; i++) r[i*DW +: DW] = 64'd1;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] r;
        for (int i = 0; i < L; i++) r[i*DW +: DW] = {$urandom(), $urandom()};
        return r;
    endfunction

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            tb_cnt     = 0;
            out_idx    = 0;
            lasts_seen = 0;
            hold       = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_stable", 64'((out_x == hx) && (out_tw == htw) &&
                                       ({out_last, out_mode} == hctl)), 64'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 64'd1, 64'd0);
                end else begin
                    b = exp_q.pop_front();
                    for (int i = 0; i < L; i++) begin
                        chk($sformatf("q_x[%0d]", i), out_x[i*DW +: DW], b.x[i*DW +: DW]);
                        chk($sformatf("q_tw[%0d]", i), out_tw[i*DW +: DW], b.tw[i*DW +: DW]);
                    end
                    chk("q_last", 64'(out_last), 64'(b.last));
                    chk("q_mode", 64'(out_mode), 64'(b.mode));
                end
                chk("last_pos", 64'(out_last), 64'((out_idx % B) == B - 1));
                if (out_last) lasts_seen++;
                out_idx++;
            end
            hold = out_valid && !out_ready;
            hx   = out_x;
            htw  = out_tw;
            hctl = {out_last, out_mode};
            if (in_valid && in_ready) begin
                b.x    = m_x(in_mode, in_x);
                b.tw   = m_tw(in_mode, in_tw);
                b.last = (tb_cnt == B - 1);
                b.mode = in_mode;
                exp_q.push_back(b);
                tb_cnt = (tb_cnt == B - 1) ? 0 : tb_cnt + 1;
            end
        end
    end

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [1:0] md, input logic [W-1:0] x, input logic [W-1:0] tw);
        bit ok;
        ok = 0;
        in_mode  = md;
        in_x     = x;
        in_tw    = tw;
        in_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_mode    = 2'd0;
        in_x       = '0;
        in_tw      = '0;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        in_mode4   = 2'd0;
        in_x4      = '0;
        in_tw4     = '0;
        out_ready4 = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_mode", 64'(out_mode), 64'd0);
        chk("rst_out_x0", out_x[0 +: DW], 64'd0);
        chk("rst_out_tw0", out_tw[0 +: DW], 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // NORMAL: x = i+1, tw = 100+i, visible one edge after acceptance
        for (int i = 0; i < L; i++) begin
            vx[i*DW +: DW]  = 64'(i + 1);
            vtw[i*DW +: DW] = 64'(100 + i);
        end
        send(2'd0, vx, vtw);
        chk("norm_valid", 64'(out_valid), 64'd1);
        chk("norm_mode", 64'(out_mode), 64'd0);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("norm_x[%0d]", i), out_x[i*DW +: DW], 64'(i + 1));
            chk($sformatf("norm_tw[%0d]", i), out_tw[i*DW +: DW], 64'(100 + i));
        end
        idle(2);

        // LAST_R2: x0=A, x1=B, tw0=5; other input lanes nonzero and must vanish
        for (int i = 0; i < L; i++) begin
            vx[i*DW +: DW]  = 64'h1000 + 64'(i);
            vtw[i*DW +: DW] = 64'h2000 + 64'(i);
        end
        vx[0 +: DW]  = 64'hA;
        vx[DW +: DW] = 64'hB;
        vtw[0 +: DW] = 64'h5;
        send(2'd1, vx, vtw);
        chk("r2_mode", 64'(out_mode), 64'd1);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("r2_x[%0d]", i), out_x[i*DW +: DW],
                (i == 0) ? 64'hA : (i == 8) ? 64'hB : 64'd0);
            chk($sformatf("r2_tw[%0d]", i), out_tw[i*DW +: DW],
                (i == 1) ? 64'h5 : 64'd0);
        end
        idle(2);

        // BYPASS with random twiddles
        vx  = rnd_vec();
        vtw = rnd_vec();
        send(2'd2, vx, vtw);
        chk("byp_mode", 64'(out_mode), 64'd2);
        for (int i = 0; i < L; i++) begin
            chk($sformatf("byp_x[%0d]", i), out_x[i*DW +: DW], vx[i*DW +: DW]);
            chk($sformatf("byp_tw[%0d]", i), out_tw[i*DW +: DW], 64'd1);
        end

        // Reserved mode routes as NORMAL
        vx  = rnd_vec();
        vtw = rnd_vec();
        send(2'd3, vx, vtw);
        chk("rsv_mode", 64'(out_mode), 64'd3);
        chk("rsv_tw3", out_tw[3*DW +: DW], vtw[3*DW +: DW]);
        chk("rsv_x9", out_x[9*DW +: DW], vx[9*DW +: DW]);
        idle(2);

        // Backpressure: A fills output, B fills skid, C must stall
        out_ready = 1'b0;
        vx = rnd_vec();
        a_lane0 = vx[0 +: DW];
        send(2'd0, vx, rnd_vec());
        send(2'd1, rnd_vec(), rnd_vec());
        in_mode  = 2'd2;
        in_x     = rnd_vec();
        in_tw    = rnd_vec();
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_head_x0", out_x[0 +: DW], a_lane0);
        out_ready = 1'b1;
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("bp_timeout", 64'd0, 64'd1);
        idle(4);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("bp_out_idle", 64'(out_valid), 64'd0);

        // Mixed modes under random backpressure
        rand_ready = 1;
        for (int k = 0; k < 40; k++) send(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec());
        rand_ready = 0;
        out_ready  = 1'b1;
        idle(4);
        chk("mix_drained", 64'(exp_q.size()), 64'd0);

        // 2*BEATS continuous beats after a fresh reset: last on 63 and 127
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2 * B; k++) begin
            vx = '0;
            vx[0 +: DW] = 64'(k);
            send(2'd0, vx, rnd_vec());
        end
        idle(3);
        chk("last_count", 64'(lasts_seen), 64'd2);
        chk("stage_drained", 64'(exp_q.size()), 64'd0);

        // Mid-stream reset with the counter one short of wrap
        for (int k = 0; k < B - 1; k++) send(2'd0, rnd_vec(), rnd_vec());
        out_ready = 1'b0;
        send(2'd0, rnd_vec(), rnd_vec());
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_x0", out_x[0 +: DW], 64'd0);
        chk("mid_rst_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_idle", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(2'd0, rnd_vec(), rnd_vec());
        chk("mid_rst_first_valid", 64'(out_valid), 64'd1);
        chk("mid_rst_first_last", 64'(out_last), 64'd0);
        idle(2);

        // LANES=4 build: BYPASS beats, last on the 4th
        for (int k = 0; k < 4; k++) begin
            in_valid4 = 1'b1;
            in_mode4  = 2'd2;
            for (int j = 0; j < 4; j++) in_x4[j*16 +: 16] = 16'(16'h100 * k + j);
            in_tw4 = {$urandom(), $urandom()};
            @(posedge clk);
            #1;
            chk("l4_valid", 64'(out_valid4), 64'd1);
            chk("l4_last", 64'(out_last4), 64'(k == 3));
            for (int j = 0; j < 4; j++) begin
                e16 = 16'(16'h100 * k + j);
                chk($sformatf("l4_x[%0d]", j), 64'(out_x4[j*16 +: 16]), 64'(e16));
                chk($sformatf("l4_tw[%0d]", j), 64'(out_tw4[j*16 +: 16]), 64'h1);
            end
        end
        // LANES=4 LAST_R2: x1 lands on lane 2, tw0 on lane 1
        in_mode4 = 2'd1;
        in_x4    = 64'h4444_3333_2222_1111;
        in_tw4   = 64'h8888_7777_6666_5555;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        chk("l4_r2_x", out_x4, 64'h0000_2222_0000_1111);
        chk("l4_r2_tw", out_tw4, 64'h0000_0000_5555_0000);
        chk("l4_r2_last", 64'(out_last4), 64'd0);
        @(posedge clk);
        #1;
        chk("l4_idle", 64'(out_valid4), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
